// File: rtl/ins_align_queue_if.sv
// Fetch-side and decode-side signal bundle for the instruction alignment queue.
// The slave modport is the queue's view; the master modport is the
// environment's view (fetch unit and decoder together).
interface ins_align_queue_if #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             fetch_valid;
    logic             fetch_ready;
    logic [31:0]      fetch_word;
    logic             flush;
    logic [PC_W-1:0]  flush_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_ins;
    logic [PC_W-1:0]  out_pc;
    logic             out_is_compressed;
    logic             out_is_branch;
    logic             out_is_jal;
    logic             out_is_jalr;
    logic [PC_W-1:0]  out_pred_pc;
    logic [OCC_W-1:0] occupancy;

    modport slave (
        input  fetch_valid, fetch_word, flush, flush_pc, out_ready,
        output fetch_ready, out_valid, out_ins, out_pc, out_is_compressed,
               out_is_branch, out_is_jal, out_is_jalr, out_pred_pc, occupancy
    );

    modport master (
        output fetch_valid, fetch_word, flush, flush_pc, out_ready,
        input  fetch_ready, out_valid, out_ins, out_pc, out_is_compressed,
               out_is_branch, out_is_jal, out_is_jalr, out_pred_pc, occupancy
    );
endinterface

// File: rtl/ins_align_queue.sv
// RV32IC fetch-to-decode alignment queue. Fetch words are split into 16-bit
// parcels held in a circular buffer; the head is realigned into one 16- or
// 32-bit instruction per cycle and registered with PC, length and a simple
// branch pre-decode that yields a predicted next PC.
module ins_align_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    ins_align_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [OW-1:0] occ_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // J-type immediate, sign-extended to PC width
    function automatic logic signed [PC_W-1:0] imm_j(input logic [31:0] ins);
        logic signed [20:0] imm;
        imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return PC_W'(imm);
    endfunction

    // B-type immediate, sign-extended to PC width
    function automatic logic signed [PC_W-1:0] imm_b(input logic [31:0] ins);
        logic signed [12:0] imm;
        imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return PC_W'(imm);
    endfunction

    // Static prediction: jal taken, backward branches taken, else fall through
    function automatic logic [PC_W-1:0] pred_next(input logic [31:0] ins,
                                                  input logic comp,
                                                  input logic [PC_W-1:0] pc);
        if (comp)
            return pc + PC_W'(2);
        else if (ins[6:0] == OP_JAL)
            return pc + $unsigned(imm_j(ins));
        else if ((ins[6:0] == OP_BRANCH) && ins[31])
            return pc + $unsigned(imm_b(ins));
        else
            return pc + PC_W'(4);
    endfunction

    logic [15:0]     queue_mem [DEPTH];
    ptr_t            head;
    ptr_t            tail;
    occ_t            occ;
    logic [PC_W-1:0] head_pc;
    logic            skip_low;

    logic            vld_p1;
    logic [31:0]     ins_p1;
    logic [PC_W-1:0] pc_p1;
    logic [PC_W-1:0] pred_p1;
    logic            comp_p1;
    logic            br_p1;
    logic            jal_p1;
    logic            jalr_p1;

    ptr_t            head_nx;
    logic [15:0]     par_lo_p0;
    logic [15:0]     par_hi_p0;
    logic            comp_p0;
    logic [31:0]     ins_p0;
    logic            br_p0;
    logic            jal_p0;
    logic            jalr_p0;
    logic            issue_p0;
    logic            load_p0;
    logic            deq_p0;
    logic            enq;
    logic            fetch_ready_int;
    occ_t            enq_n;
    occ_t            deq_n;

    // ---- stage p0: head realignment, pre-decode and handshake decisions ----
    // Select the instruction at the head and decide enqueue/dequeue counts
    always_comb begin
        head_nx   = head + ptr_t'(1);
        par_lo_p0 = queue_mem[head];
        par_hi_p0 = queue_mem[head_nx];
        comp_p0   = (par_lo_p0[1:0] != 2'b11);
        ins_p0    = comp_p0 ? {16'h0000, par_lo_p0} : {par_hi_p0, par_lo_p0};
        br_p0     = ~comp_p0 & (ins_p0[6:0] == OP_BRANCH);
        jal_p0    = ~comp_p0 & (ins_p0[6:0] == OP_JAL);
        jalr_p0   = ~comp_p0 & (ins_p0[6:0] == OP_JALR);

        // A 32-bit head needs both of its parcels before it can leave
        issue_p0  = (occ != '0) & (comp_p0 | (occ >= occ_t'(2)));
        load_p0   = rdy_in & (~vld_p1 | bus.out_ready);
        deq_p0    = load_p0 & issue_p0 & ~bus.flush;

        // Registered occupancy only: no credit for a same-cycle dequeue
        fetch_ready_int = rst_in & rdy_in & ~bus.flush & (occ <= occ_t'(DEPTH - 2));
        enq       = bus.fetch_valid & fetch_ready_int;

        enq_n     = '0;
        if (enq)
            enq_n = skip_low ? occ_t'(1) : occ_t'(2);
        deq_n     = '0;
        if (deq_p0)
            deq_n = comp_p0 ? occ_t'(1) : occ_t'(2);
    end

    // Parcel storage: write one or both halves of the accepted fetch word
    always_ff @(posedge clk_in) begin
        if (enq) begin
            if (skip_low) begin
                queue_mem[tail] <= bus.fetch_word[31:16];
            end else begin
                queue_mem[tail]              <= bus.fetch_word[15:0];
                queue_mem[tail + ptr_t'(1)]  <= bus.fetch_word[31:16];
            end
        end
    end

    // Queue pointers, occupancy, PC tracking and output valid
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            head_pc  <= '0;
            skip_low <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (rdy_in) begin
            if (bus.flush) begin
                head     <= '0;
                tail     <= '0;
                occ      <= '0;
                head_pc  <= bus.flush_pc;
                skip_low <= bus.flush_pc[1];
                vld_p1   <= 1'b0;
            end else begin
                occ <= occ + enq_n - deq_n;
                if (enq) begin
                    tail     <= tail + (skip_low ? ptr_t'(1) : ptr_t'(2));
                    skip_low <= 1'b0;
                end
                if (deq_p0) begin
                    head    <= head + (comp_p0 ? ptr_t'(1) : ptr_t'(2));
                    head_pc <= head_pc + (comp_p0 ? PC_W'(2) : PC_W'(4));
                end
                if (load_p0)
                    vld_p1 <= issue_p0;
            end
        end
    end

    // ---- stage p1: registered instruction output ----
    // Capture the issued instruction and its pre-decode
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ins_p1  <= '0;
            pc_p1   <= '0;
            pred_p1 <= '0;
            comp_p1 <= 1'b0;
            br_p1   <= 1'b0;
            jal_p1  <= 1'b0;
            jalr_p1 <= 1'b0;
        end else if (deq_p0) begin
            ins_p1  <= ins_p0;
            pc_p1   <= head_pc;
            pred_p1 <= pred_next(ins_p0, comp_p0, head_pc);
            comp_p1 <= comp_p0;
            br_p1   <= br_p0;
            jal_p1  <= jal_p0;
            jalr_p1 <= jalr_p0;
        end
    end

    assign bus.fetch_ready       = fetch_ready_int;
    assign bus.out_valid         = vld_p1;
    assign bus.out_ins           = ins_p1;
    assign bus.out_pc            = pc_p1;
    assign bus.out_pred_pc       = pred_p1;
    assign bus.out_is_compressed = comp_p1;
    assign bus.out_is_branch     = br_p1;
    assign bus.out_is_jal        = jal_p1;
    assign bus.out_is_jalr       = jalr_p1;
    assign bus.occupancy         = occ;
endmodule

// File: tb/tb_ins_align_queue.sv
// Testbench for ins_align_queue: an instruction-stream model fills a
// scoreboard as fetch words are accepted; a negedge monitor pops and compares
// each instruction the decoder side accepts. Scenario tasks add direct checks.
module tb_ins_align_queue;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    ins_align_queue_if #(.DEPTH(8), .PC_W(32)) bus ();

    ins_align_queue #(.DEPTH(8), .PC_W(32)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        comp;
        logic        br;
        logic        jal;
        logic        jalr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_par[$];
    logic [31:0] m_pc;
    logic        m_skip;
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] model_pred(input logic [31:0] i, input logic [31:0] pc);
        logic [31:0] jimm;
        logic [31:0] bimm;
        jimm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        bimm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        if (i[1:0] != 2'b11)               return pc + 32'd2;
        if (i[6:0] == 7'h6F)               return pc + jimm;
        if ((i[6:0] == 7'h63) && i[31])    return pc + bimm;
        return pc + 32'd4;
    endfunction

    function automatic void model_decode();
        exp_t        e;
        logic [31:0] ins;
        bit          more;
        more = 1;
        while (more) begin
            more = 0;
            if (m_par.size() >= 1 && m_par[0][1:0] != 2'b11) begin
                ins = {16'h0000, m_par[0]};
                void'(m_par.pop_front());
                e.comp = 1'b1;
                more = 1;
            end else if (m_par.size() >= 2) begin
                ins = {m_par[1], m_par[0]};
                void'(m_par.pop_front());
                void'(m_par.pop_front());
                e.comp = 1'b0;
                more = 1;
            end
            if (more) begin
                e.ins  = ins;
                e.pc   = m_pc;
                e.pred = model_pred(ins, m_pc);
                e.br   = !e.comp && ins[6:0] == 7'h63;
                e.jal  = !e.comp && ins[6:0] == 7'h6F;
                e.jalr = !e.comp && ins[6:0] == 7'h67;
                m_pc   = m_pc + (e.comp ? 32'd2 : 32'd4);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void model_push(input logic [31:0] w);
        if (!m_skip) m_par.push_back(w[15:0]);
        m_par.push_back(w[31:16]);
        m_skip = 1'b0;
        model_decode();
    endfunction

    function automatic void model_flush(input logic [31:0] pc);
        m_par.delete();
        exp_q.delete();
        m_pc   = pc;
        m_skip = pc[1];
    endfunction

    // Scoreboard monitor: inputs are stable at the negedge for the next edge
    always @(negedge clk_in) begin
        if (rst_in && rdy_in && !bus.flush) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got ins=%h pc=%h, required no output", bus.out_ins, bus.out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.out_ins !== mon_e.ins || bus.out_pc !== mon_e.pc || bus.out_pred_pc !== mon_e.pred ||
                        bus.out_is_compressed !== mon_e.comp || bus.out_is_branch !== mon_e.br ||
                        bus.out_is_jal !== mon_e.jal || bus.out_is_jalr !== mon_e.jalr) begin
                        failures++;
                        $display("FAIL sb_out got ins=%h pc=%h pred=%h cbjr=%b%b%b%b exp ins=%h pc=%h pred=%h cbjr=%b%b%b%b",
                                 bus.out_ins, bus.out_pc, bus.out_pred_pc, bus.out_is_compressed, bus.out_is_branch,
                                 bus.out_is_jal, bus.out_is_jalr, mon_e.ins, mon_e.pc, mon_e.pred,
                                 mon_e.comp, mon_e.br, mon_e.jal, mon_e.jalr);
                    end
                end
            end
            if (bus.fetch_valid && bus.fetch_ready) model_push(bus.fetch_word);
        end
    end

    // Stimulus tasks start and end at 1 time unit after a rising edge
    task automatic send_word(input logic [31:0] w);
        bit done;
        done = 0;
        bus.fetch_valid = 1'b1;
        bus.fetch_word  = w;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk_in);
            done = bus.fetch_ready;
            @(posedge clk_in);
            #1;
        end
        bus.fetch_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout word=%h fetch_ready=%b required=1", w, bus.fetch_ready);
        end
    endtask

    task automatic flush_to(input logic [31:0] pc);
        bus.flush    = 1'b1;
        bus.flush_pc = pc;
        model_flush(pc);
        @(posedge clk_in);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d out_valid=%b required 0/0", name, exp_q.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.fetch_word  = 32'h00A00093;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (bus.fetch_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got fetch_ready=%b out_valid=%b required 0 0", bus.fetch_ready, bus.out_valid);
        end
        checks++;
        if (bus.out_ins !== 32'h0 || bus.out_pc !== 32'h0 || bus.out_pred_pc !== 32'h0 || bus.occupancy !== 4'd0) begin
            failures++;
            $display("FAIL reset_outs got ins=%h pc=%h pred=%h occ=%0d required all 0",
                     bus.out_ins, bus.out_pc, bus.out_pred_pc, bus.occupancy);
        end
        bus.fetch_valid = 1'b0;
        rst_in = 1'b1;
        model_flush(32'h0);
        #1;
        checks++;
        if (bus.fetch_ready !== 1'b1 || bus.occupancy !== 4'd0) begin
            failures++;
            $display("FAIL reset_release got fetch_ready=%b occ=%0d required 1 0", bus.fetch_ready, bus.occupancy);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_jal();
        bus.out_ready = 1'b1;
        flush_to(32'h1000);
        send_word(32'h00A00093);
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1000 || bus.out_pred_pc !== 32'h1004 || bus.out_is_jal !== 1'b0) begin
            failures++;
            $display("FAIL jal_first got v=%b pc=%h pred=%h jal=%b required 1 1000 1004 0",
                     bus.out_valid, bus.out_pc, bus.out_pred_pc, bus.out_is_jal);
        end
        send_word(32'h0FC0006F);
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1004 || bus.out_pred_pc !== 32'h1100 || bus.out_is_jal !== 1'b1) begin
            failures++;
            $display("FAIL jal_second got v=%b pc=%h pred=%h jal=%b required 1 1004 1100 1",
                     bus.out_valid, bus.out_pc, bus.out_pred_pc, bus.out_is_jal);
        end
        drain("jal");
    endtask

    task automatic test_straddle();
        flush_to(32'h2000);
        send_word(32'h00934505);
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h2000 || bus.out_ins !== 32'h00004505 || bus.out_is_compressed !== 1'b1) begin
            failures++;
            $display("FAIL straddle_cli got v=%b pc=%h ins=%h c=%b required 1 2000 00004505 1",
                     bus.out_valid, bus.out_pc, bus.out_ins, bus.out_is_compressed);
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 4'd1) begin
            failures++;
            $display("FAIL straddle_wait got v=%b occ=%0d required 0 1", bus.out_valid, bus.occupancy);
        end
        send_word(32'h00000013);
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h2002 || bus.out_ins !== 32'h00130093 || bus.out_is_compressed !== 1'b0) begin
            failures++;
            $display("FAIL straddle_32 got v=%b pc=%h ins=%h c=%b required 1 2002 00130093 0",
                     bus.out_valid, bus.out_pc, bus.out_ins, bus.out_is_compressed);
        end
        drain("straddle");
    endtask

    task automatic test_skip_low();
        flush_to(32'h3002);
        send_word(32'h45051234);
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3002 || bus.out_ins !== 32'h00004505 || bus.occupancy !== 4'd0) begin
            failures++;
            $display("FAIL skip_low got v=%b pc=%h ins=%h occ=%0d required 1 3002 00004505 0",
                     bus.out_valid, bus.out_pc, bus.out_ins, bus.occupancy);
        end
        drain("skip");
    endtask

    task automatic test_full_wrap();
        bus.out_ready = 1'b0;
        flush_to(32'h4002);
        send_word(32'h45051234);
        send_word(32'h00100093);
        send_word(32'h00200113);
        send_word(32'h00300193);
        send_word(32'h00400213);
        checks++;
        if (bus.occupancy !== 4'd8 || bus.fetch_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4002) begin
            failures++;
            $display("FAIL full_state got occ=%0d fr=%b v=%b pc=%h required 8 0 1 4002",
                     bus.occupancy, bus.fetch_ready, bus.out_valid, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.occupancy !== 4'd6 || bus.fetch_ready !== 1'b1 || bus.out_pc !== 32'h4004) begin
            failures++;
            $display("FAIL full_resume got occ=%0d fr=%b pc=%h required 6 1 4004",
                     bus.occupancy, bus.fetch_ready, bus.out_pc);
        end
        send_word(32'h00500293);
        drain("wrap");
    endtask

    task automatic test_flush_stream();
        bus.out_ready = 1'b0;
        flush_to(32'h5000);
        send_word(32'h00100093);
        send_word(32'h00200113);
        send_word(32'h00300193);
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h6000;
        bus.fetch_valid = 1'b1;
        bus.fetch_word  = 32'h00700393;
        model_flush(32'h6000);
        #1;
        checks++;
        if (bus.fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_fetch_ready got %b required 0", bus.fetch_ready);
        end
        @(posedge clk_in);
        #1;
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 4'd0) begin
            failures++;
            $display("FAIL flush_empty got v=%b occ=%0d required 0 0", bus.out_valid, bus.occupancy);
        end
        bus.out_ready = 1'b1;
        send_word(32'h00600313);
        drain("flush");
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b1;
        flush_to(32'h7000);
        send_word(32'h00100093);
        send_word(32'h00200113);
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h7000 || bus.out_ins !== 32'h00100093 ||
                bus.occupancy !== 4'd2 || bus.fetch_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold c=%0d got v=%b pc=%h ins=%h occ=%0d fr=%b required 1 7000 00100093 2 0",
                         c, bus.out_valid, bus.out_pc, bus.out_ins, bus.occupancy, bus.fetch_ready);
            end
        end
        rdy_in = 1'b1;
        drain("stall");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        flush_to(32'h8000);
        flush_to(32'h8002);
        send_word(32'h45051234);
        send_word(32'hFE000CE3);
        send_word(32'h00008067);
        send_word(32'h00000463);
        send_word(32'h00100093);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h800C || bus.out_is_branch !== 1'b1 || bus.out_pred_pc !== 32'h8010) begin
            failures++;
            $display("FAIL b2b_fwd_branch got v=%b pc=%h br=%b pred=%h required 1 800c 1 8010",
                     bus.out_valid, bus.out_pc, bus.out_is_branch, bus.out_pred_pc);
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8010) begin
            failures++;
            $display("FAIL b2b_next got v=%b pc=%h required 1 8010", bus.out_valid, bus.out_pc);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        flush_to(32'h9000);
        send_word(32'h00100093);
        send_word(32'h00200113);
        rst_in = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 4'd0 || bus.out_pc !== 32'h0 || bus.fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got v=%b occ=%0d pc=%h fr=%b required 0 0 0 0",
                     bus.out_valid, bus.occupancy, bus.out_pc, bus.fetch_ready);
        end
        model_flush(32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        drain("reset_mid");
    endtask

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_word  = 32'h0;
        bus.flush       = 1'b0;
        bus.flush_pc    = 32'h0;
        bus.out_ready   = 1'b1;
        m_pc   = 32'h0;
        m_skip = 1'b0;
        test_reset();
        test_jal();
        test_straddle();
        test_skip_low();
        test_full_wrap();
        test_flush_stream();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
